// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types, activation codes and saturation helper for the layer engine
//
// Contents:
//   state_t       sequencer states
//   ACT_*         activation mode codes (code 3 behaves as identity)
//   saturate()    clip a sign-extended value into a dw-bit signed range
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    WRITEBACK,
    OUTPUT
  } state_t;

  localparam logic [1:0] ACT_IDENTITY = 2'd0;
  localparam logic [1:0] ACT_RELU     = 2'd1;
  localparam logic [1:0] ACT_STEP     = 2'd2;

  // Works on a 64-bit sign-extended value so one helper covers any
  // accumulator width; the caller compares input and output to detect clipping.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/nn_layer_engine_if.sv
// rtl/nn_layer_engine_if.sv - input stream, weight RAM port and output stream bundle
//
// Signals:
//   in_valid/in_ready/in_data            input activation stream
//   w_en/w_addr/w_data                   synchronous weight RAM read port (1-cycle latency)
//   out_valid/out_ready/out_data/out_last result stream
// Modports:
//   master  environment side (source of inputs, weight RAM, result sink)
//   slave   engine side
interface nn_layer_engine_if #(
  parameter int N_NODES  = 4,
  parameter int N_LAYERS = 3,
  parameter int DW       = 8,
  parameter int WW       = 8
);
  localparam int AW = $clog2(N_LAYERS * N_NODES);

  logic                  in_valid;
  logic                  in_ready;
  logic [DW-1:0]         in_data;
  logic                  w_en;
  logic [AW-1:0]         w_addr;
  logic [N_NODES*WW-1:0] w_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, w_data, out_ready,
    input  in_ready, w_en, w_addr, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, w_data, out_ready,
    output in_ready, w_en, w_addr, out_valid, out_data, out_last
  );

endinterface

// File: rtl/nn_mac_unit.sv
// rtl/nn_mac_unit.sv - one node: signed MAC accumulator plus shift/saturate/activation writeback path
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        zero the accumulator (layer start)
//   en           accumulate act*weight this cycle
//   act, weight  aligned signed operands
//   mode         activation code
//   acc_out      raw accumulator
//   result       activated, saturated node output (combinational from acc)
//   sat          result was clipped during saturation
module nn_mac_unit
  import nn_pkg::*;
#(
  parameter int DW        = 8,
  parameter int WW        = 8,
  parameter int FRAC_BITS = 4,
  parameter int ACC_W     = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [DW-1:0]    act,
  input  logic signed [WW-1:0]    weight,
  input  logic [1:0]              mode,
  output logic signed [ACC_W-1:0] acc_out,
  output logic signed [DW-1:0]    result,
  output logic                    sat
);

  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [DW+WW-1:0]   prod;
  logic signed [ACC_W-1:0]   r;
  logic signed [63:0]        r_ext;
  logic signed [63:0]        r_sat;
  logic signed [DW-1:0]      r_dw;

  assign prod    = act * weight;
  assign acc_out = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    r      = acc_q >>> FRAC_BITS;
    r_ext  = 64'(r);
    r_sat  = saturate(r_ext, DW);
    r_dw   = r_sat[DW-1:0];
    sat    = (r_sat != r_ext);
    result = r_dw;
    case (mode)
      ACT_RELU: result = r_dw[DW-1] ? '0 : r_dw;
      ACT_STEP: result = (r_dw > 0) ? DW'(1) : '0;
      default:  result = r_dw;
    endcase
  end

endmodule

// File: rtl/nn_layer_engine.sv
// rtl/nn_layer_engine.sv - N_NODES-wide fully connected engine evaluating N_LAYERS layers per run
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        begin a run (sampled in IDLE)
//   act_mode     activation code, latched at start
//   bus          slave side of nn_layer_engine_if (input stream, weight RAM, output stream)
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the last output handshake
//   sat_flag     sticky saturation indicator for the current run
module nn_layer_engine
  import nn_pkg::*;
#(
  parameter int N_NODES   = 4,
  parameter int N_LAYERS  = 3,
  parameter int DW        = 8,
  parameter int WW        = 8,
  parameter int FRAC_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          act_mode,
  nn_layer_engine_if.slave    bus,
  output logic                busy,
  output logic                done,
  output logic                sat_flag
);

  localparam int IW    = $clog2(N_NODES);
  localparam int LW    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int AW    = $clog2(N_LAYERS * N_NODES);
  localparam int ACC_W = DW + WW + $clog2(N_NODES);

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          k_q;
  logic [LW-1:0]          layer_q;
  logic [1:0]             mode_q;
  logic                   sat_q;
  logic                   done_q;
  logic                   mac_en_q;
  logic signed [DW-1:0]   act_q [N_NODES];
  logic signed [DW-1:0]   act_dly_q;

  logic                   in_fire;
  logic                   out_fire;
  logic                   last_idx;
  logic                   last_k;
  logic                   last_layer;
  logic                   acc_clear;

  logic signed [DW-1:0]    res_w [N_NODES];
  logic [N_NODES-1:0]      sat_w;
  logic signed [ACC_W-1:0] acc_unused [N_NODES];

  assign last_idx   = (idx_q == IW'(N_NODES - 1));
  assign last_k     = (k_q == IW'(N_NODES - 1));
  assign last_layer = (layer_q == LW'(N_LAYERS - 1));
  assign done       = done_q;
  assign sat_flag   = sat_q;

  always_comb begin
    state_d       = state_q;
    busy          = (state_q != IDLE);
    bus.in_ready  = 1'b0;
    bus.w_en      = 1'b0;
    bus.w_addr    = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    in_fire       = 1'b0;
    out_fire      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        bus.in_ready = 1'b1;
        in_fire      = bus.in_valid;
        if (in_fire && last_idx) state_d = COMPUTE;
      end
      COMPUTE: begin
        bus.w_en   = 1'b1;
        bus.w_addr = AW'(int'(layer_q) * N_NODES + int'(k_q));
        if (last_k) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        state_d = last_layer ? OUTPUT : COMPUTE;
      end
      OUTPUT: begin
        bus.out_valid = 1'b1;
        bus.out_data  = act_q[idx_q];
        bus.out_last  = last_idx;
        out_fire      = bus.out_ready;
        if (out_fire && last_idx) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accumulators restart on every entry into COMPUTE, from LOAD or WRITEBACK.
    acc_clear = (state_d == COMPUTE) && (state_q != COMPUTE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      k_q       <= '0;
      layer_q   <= '0;
      mode_q    <= '0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
      mac_en_q  <= 1'b0;
      act_dly_q <= '0;
      for (int i = 0; i < N_NODES; i++) act_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= 1'b0;
      // Weight word for step k arrives one cycle after its read, so the
      // activation operand and MAC enable are delayed by the same amount.
      mac_en_q  <= (state_q == COMPUTE);
      act_dly_q <= act_q[k_q];

      case (state_q)
        IDLE: begin
          if (start) begin
            sat_q  <= 1'b0;
            mode_q <= act_mode;
            idx_q  <= '0;
          end
        end
        LOAD: begin
          if (in_fire) begin
            act_q[idx_q] <= bus.in_data;
            if (last_idx) begin
              idx_q   <= '0;
              k_q     <= '0;
              layer_q <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        COMPUTE: begin
          k_q <= last_k ? '0 : k_q + 1'b1;
        end
        WRITEBACK: begin
          for (int u = 0; u < N_NODES; u++) act_q[u] <= res_w[u];
          if (|sat_w) sat_q <= 1'b1;
          if (last_layer) begin
            idx_q <= '0;
          end else begin
            layer_q <= layer_q + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            if (last_idx) begin
              idx_q  <= '0;
              done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar u = 0; u < N_NODES; u++) begin : g_unit
    nn_mac_unit #(
      .DW        (DW),
      .WW        (WW),
      .FRAC_BITS (FRAC_BITS),
      .ACC_W     (ACC_W)
    ) u_mac (
      .clk     (clk),
      .reset   (reset),
      .clear   (acc_clear),
      .en      (mac_en_q),
      .act     (act_dly_q),
      .weight  (bus.w_data[u*WW +: WW]),
      .mode    (mode_q),
      .acc_out (acc_unused[u]),
      .result  (res_w[u]),
      .sat     (sat_w[u])
    );
  end

endmodule
